mem_io_controller: RTL and testbench
====================================

// Module: mem_io_controller
// PURPOSE
//  Parametrised successor to the eLC-3 memory path. Handles CPU memory cycles with a
//  level request / Ready pulse handshake. Decodes memory-mapped I/O: KBSR, KBDR, DSR
//  and NUM_DISP display words. All other addresses go to async SRAM with WAIT_STATES
//  programmable access cycles. Sits between the Datapath/ControlUnit and the SRAM pins.
// PARAMETERS
//  DATA_W       16       CPU data width = SRAM DQ width
//  ADDR_W       16       CPU address width
//  SRAM_ADDR_W  20       SRAM address width; CPU address zero-extended
//  WAIT_STATES  2        extra SRAM access cycles (0..15); access = WAIT_STATES+1 cycles
//  NUM_DISP     1        display channels (1..4); DDR words at DDR_BASE+i
// PORTS
//  Clk                input   1                    system clock, all logic rising-edge
//  Reset              input   1                    async, active-high; clears all state
//  MIO_EN             input   1                    request; held by CPU until Ready
//  R_W                input   1                    1 = write, 0 = read; sampled with MIO_EN
//  Address            input   ADDR_W               word address; sampled at accept
//  Data_FromCPU       input   DATA_W               write data; sampled at accept
//  Data_ToCPU         output  DATA_W               read data; valid with Ready, held after
//  Ready              output  1                    one-cycle completion pulse
//  Data_FromKeyboard  input   DATA_W               keyboard word
//  KBD_Strobe         input   1                    1-cycle pulse (synchronous); loads KBDR
//  Data_ToVideo       output  NUM_DISP*DATA_W      DDR channels, ch0 in LSBs
//  SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N  output 1 each  active-low strobes
//  SRAM_ADDR          output  SRAM_ADDR_W          SRAM address, registered
//  SRAM_DQ            inout   DATA_W               driven only during SRAM_WR and SRAM_HOLD
// BEHAVIOUR
//  Reset: state IDLE, Ready=0, Data_ToCPU=0, Data_ToVideo=0, KBDR=0, KBSR=0.
//   All SRAM_*_N=1, SRAM_ADDR=0, DQ tri-stated. Reset mid-cycle aborts with no Ready.
//  FSM: IDLE, IO, SRAM_RD, SRAM_WR, SRAM_HOLD, DONE.
//   Accept happens in IDLE only, on the edge where MIO_EN=1. Address/R_W/data are captured.
//   IO-decoded address -> IO. Otherwise -> SRAM_RD (R_W=0) or SRAM_WR (R_W=1).
//  IO (1 cycle): register read mux or write -> DONE.
//   Ready is high the cycle after accept edge +1 (total 2 edges).
//  SRAM_RD: CE_N=OE_N=LB_N=UB_N=0 for WAIT_STATES+1 cycles; 4-bit wait counter.
//   DQ captured into Data_ToCPU on the last edge -> DONE.
//  SRAM_WR: CE_N=WE_N=LB_N=UB_N=0 and DQ driven for WAIT_STATES+1 cycles -> SRAM_HOLD.
//  SRAM_HOLD: WE_N=1, CE_N=0, DQ still driven (1 cycle hold) -> DONE.
//  DONE: Ready=1 for exactly one cycle -> IDLE.
//   IDLE ignores MIO_EN for that one cycle after DONE, so a held request is not re-accepted.
//  MIO_EN while busy: ignored; no queueing. R_W/Address changes mid-access: ignored.
//  IO map: KBSR=FE00, KBDR=FE02, DSR=FE04, DDR_BASE=FE06..FE06+NUM_DISP-1.
//   Other FExx/FFxx -> SRAM.
//  KBSR[15] is set on KBD_Strobe, which also loads KBDR; other KBSR bits read 0.
//   A KBDR read clears KBSR[15] in the IO cycle.
//   Strobe and KBDR read in the same cycle: read returns old KBDR.
//   New data is latched and KBSR[15] stays 1 (strobe wins).
//  DSR reads 16'h8000 (always ready). Writes to KBSR/KBDR/DSR are ignored, Ready still pulses.
//  DDR write updates channel i in the IO cycle; a DDR read returns channel i.
//  SRAM_ADDR = {zero pad, Address}; only SRAM_ADDR_W >= ADDR_W is legal (elaboration assert).
// STRUCTURE
//  Package elc3_mem_pkg: state enum mem_state_t, IO address localparams, DATA_W default.
//  Single module; wait counter and IO decode inline; no sub-module needed.
//  SRAM_DQ tri-state via a registered output-enable; no combinational path from MIO_EN to pins.
// TESTING
//  Reset mid SRAM_WR (WE_N=0) -> next cycle all SRAM_*_N=1, DQ=Z, Ready never pulses.
//  WAIT_STATES=2: write 0x1234 to 0x3000, then read 0x3000.
//   -> WE_N low 3 cycles, Ready on edge 5 after accept.
//   -> read Ready on edge 4 with Data_ToCPU=0x1234.
//  KBD_Strobe with 0x0041, read FE00 -> 0x8000.
//   -> read FE02 -> 0x0041; read FE00 again -> 0x0000.
//  Strobe 0x0042 in the same cycle as a KBDR read of 0x0041 -> read returns 0x0041, KBSR=0x8000.
//  NUM_DISP=2: write 0xBEEF to FE07 -> Data_ToVideo=32'hBEEF_0000.
//   -> FE07 reads 0xBEEF; Ready 2 edges after accept.
//  MIO_EN held 10 cycles on one read -> exactly one Ready pulse; MIO_EN toggled during RD -> ignored.

Source files
------------

// File: rtl/elc3_mem_pkg.sv
// elc3_mem_pkg: shared state encoding and memory-mapped I/O addresses
package elc3_mem_pkg;
  localparam int DEF_DATA_W = 16;
  typedef enum logic [2:0] {IDLE, IO, SRAM_RD, SRAM_WR, SRAM_HOLD, DONE} mem_state_t;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_BASE  = 16'hFE06;
endpackage

// File: rtl/mem_io_controller.sv
// mem_io_controller: CPU memory cycles to async SRAM plus keyboard/display I/O registers
module mem_io_controller
  import elc3_mem_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = 16,
  parameter int SRAM_ADDR_W = 20,
  parameter int WAIT_STATES = 2,
  parameter int NUM_DISP    = 1
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       MIO_EN,
  input  logic                       R_W,
  input  logic [ADDR_W-1:0]          Address,
  input  logic [DATA_W-1:0]          Data_FromCPU,
  output logic [DATA_W-1:0]          Data_ToCPU,
  output logic                       Ready,
  input  logic [DATA_W-1:0]          Data_FromKeyboard,
  input  logic                       KBD_Strobe,
  output logic [NUM_DISP*DATA_W-1:0] Data_ToVideo,
  output logic                       SRAM_CE_N,
  output logic                       SRAM_OE_N,
  output logic                       SRAM_WE_N,
  output logic                       SRAM_LB_N,
  output logic                       SRAM_UB_N,
  output logic [SRAM_ADDR_W-1:0]     SRAM_ADDR,
  inout  wire  [DATA_W-1:0]          SRAM_DQ
);
  localparam int IDX_W = NUM_DISP > 1 ? $clog2(NUM_DISP) : 1;
  localparam logic [DATA_W-1:0] BIT15 = DATA_W'(16'h8000);
  if (SRAM_ADDR_W < ADDR_W || WAIT_STATES < 0 || WAIT_STATES > 15 || NUM_DISP < 1 || NUM_DISP > 4) begin : g_bad_params
    $error("mem_io_controller: illegal parameter combination");
  end
  mem_state_t state;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, kbdr, dq_out, io_rdata;
  logic rw_q, kbsr_flag, dq_oe;
  logic [NUM_DISP-1:0][DATA_W-1:0] ddr;
  logic [IDX_W-1:0] ddr_idx;
  logic io_hit;
  function automatic logic is_ddr(input logic [ADDR_W-1:0] a);
    return a >= ADDR_W'(DDR_BASE) && a < ADDR_W'(DDR_BASE) + ADDR_W'(NUM_DISP);
  endfunction
  assign io_hit = Address == ADDR_W'(KBSR_ADDR) || Address == ADDR_W'(KBDR_ADDR) ||
                  Address == ADDR_W'(DSR_ADDR) || is_ddr(Address);
  assign ddr_idx = IDX_W'(addr_q - ADDR_W'(DDR_BASE));
  assign io_rdata = addr_q == ADDR_W'(KBSR_ADDR) ? (kbsr_flag ? BIT15 : '0) :
                    addr_q == ADDR_W'(KBDR_ADDR) ? kbdr :
                    addr_q == ADDR_W'(DSR_ADDR)  ? BIT15 :
                    is_ddr(addr_q)               ? ddr[ddr_idx] : '0;
  assign Data_ToVideo = ddr;
  assign SRAM_DQ = dq_oe ? dq_out : 'z;
  // Strobes and DQ enable are registered so the SRAM pins never follow MIO_EN combinationally
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rw_q       <= 1'b0;
      Ready      <= 1'b0;
      Data_ToCPU <= '0;
      kbdr       <= '0;
      kbsr_flag  <= 1'b0;
      ddr        <= '0;
      SRAM_CE_N  <= 1'b1;
      SRAM_OE_N  <= 1'b1;
      SRAM_WE_N  <= 1'b1;
      SRAM_LB_N  <= 1'b1;
      SRAM_UB_N  <= 1'b1;
      SRAM_ADDR  <= '0;
      dq_oe      <= 1'b0;
      dq_out     <= '0;
    end else begin
      Ready <= 1'b0;
      if (KBD_Strobe) begin
        kbdr      <= Data_FromKeyboard;
        kbsr_flag <= 1'b1;
      end
      case (state)
        // Ready is high during the first IDLE cycle, which blocks re-accepting a held request
        IDLE: if (MIO_EN && !Ready) begin
          addr_q  <= Address;
          wdata_q <= Data_FromCPU;
          rw_q    <= R_W;
          cnt     <= '0;
          if (io_hit) state <= IO;
          else begin
            SRAM_ADDR <= SRAM_ADDR_W'(Address);
            SRAM_CE_N <= 1'b0;
            SRAM_LB_N <= 1'b0;
            SRAM_UB_N <= 1'b0;
            SRAM_OE_N <= R_W;
            SRAM_WE_N <= ~R_W;
            dq_oe     <= R_W;
            dq_out    <= Data_FromCPU;
            state     <= R_W ? SRAM_WR : SRAM_RD;
          end
        end
        IO: begin
          if (!rw_q) Data_ToCPU <= io_rdata;
          if (!rw_q && addr_q == ADDR_W'(KBDR_ADDR)) kbsr_flag <= KBD_Strobe;
          if (rw_q && is_ddr(addr_q)) ddr[ddr_idx] <= wdata_q;
          state <= DONE;
        end
        SRAM_RD: if (cnt == 4'(WAIT_STATES)) begin
          Data_ToCPU <= SRAM_DQ;
          SRAM_CE_N  <= 1'b1;
          SRAM_OE_N  <= 1'b1;
          SRAM_LB_N  <= 1'b1;
          SRAM_UB_N  <= 1'b1;
          state      <= DONE;
        end else cnt <= cnt + 4'd1;
        SRAM_WR: if (cnt == 4'(WAIT_STATES)) begin
          SRAM_WE_N <= 1'b1;
          state     <= SRAM_HOLD;
        end else cnt <= cnt + 4'd1;
        SRAM_HOLD: begin
          SRAM_CE_N <= 1'b1;
          SRAM_LB_N <= 1'b1;
          SRAM_UB_N <= 1'b1;
          dq_oe     <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          Ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_io_controller.sv
// tb_mem_io_controller: directed vectors against mem_io_controller with a small SRAM model
module tb_mem_io_controller;
  logic clk = 1'b0, rst = 1'b1;
  logic mio_en = 1'b0, r_w = 1'b0, kbd_stb = 1'b0;
  logic [15:0] address = '0, wdata = '0, kbd_data = '0, rdata;
  logic ready, ce_n, oe_n, we_n, lb_n, ub_n;
  logic [31:0] video;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;
  logic [15:0] mem [256];
  logic init_mem = 1'b1;
  int vectors = 0, errors = 0, edges, we_cnt, pulses;
  logic [15:0] rd, dq0;
  logic [19:0] sa0;
  logic got;

  mem_io_controller #(.DATA_W(16), .ADDR_W(16), .SRAM_ADDR_W(20), .WAIT_STATES(2), .NUM_DISP(2)) dut (
    .Clk(clk), .Reset(rst), .MIO_EN(mio_en), .R_W(r_w), .Address(address),
    .Data_FromCPU(wdata), .Data_ToCPU(rdata), .Ready(ready),
    .Data_FromKeyboard(kbd_data), .KBD_Strobe(kbd_stb), .Data_ToVideo(video),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq)
  );

  always #5 clk = ~clk;
  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 'z;
  always @(posedge clk)
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8] <= 16'hA5A5;
    end else if (!ce_n && !we_n) mem[sram_addr[7:0]] <= sram_dq;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    vectors++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
    end
  endtask

  // One CPU cycle; optional keyboard strobe lands in the cycle after the accept edge
  task automatic op(input logic rw, input logic [15:0] a, input logic [15:0] d,
                    input logic stb, input logic [15:0] sd);
    mio_en = 1'b1; r_w = rw; address = a; wdata = d;
    @(posedge clk);
    edges = 0; we_cnt = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (i == 0) begin
        sa0 = sram_addr; dq0 = sram_dq; kbd_stb = stb; kbd_data = sd;
      end else kbd_stb = 1'b0;
      if (!we_n) we_cnt++;
      if (ready) begin
        got = 1'b1; rd = rdata; mio_en = 1'b0;
      end else begin
        @(posedge clk); edges++;
      end
    end
    mio_en = 1'b0; kbd_stb = 1'b0;
    check($sformatf("ready_seen_%h", a), 32'(got), 32'h1);
    @(posedge clk); @(negedge clk);
  endtask

  task automatic strobe(input logic [15:0] d);
    kbd_stb = 1'b1; kbd_data = d;
    @(negedge clk);
    kbd_stb = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_video", video, 32'h0);
    check("rst_sram_addr", 32'(sram_addr), 32'h0);
    check("rst_strobes", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1f);
    rst = 1'b0; init_mem = 1'b0;
    @(negedge clk);
    op(1'b1, 16'h3000, 16'h1234, 1'b0, 16'h0);
    check("wr_edges", 32'(edges), 32'd5);
    check("wr_we_cycles", 32'(we_cnt), 32'd3);
    check("wr_sram_addr", 32'(sa0), 32'h03000);
    check("wr_dq", 32'(dq0), 32'h1234);
    check("wr_ready_pulse", 32'(ready), 32'h0);
    check("wr_strobes_idle", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1f);
    op(1'b0, 16'h3000, 16'h0, 1'b0, 16'h0);
    check("rd_edges", 32'(edges), 32'd4);
    check("rd_data", 32'(rd), 32'h1234);
    // request toggled and address/direction changed mid-read
    mio_en = 1'b1; r_w = 1'b0; address = 16'h3000;
    @(posedge clk);
    edges = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      mio_en = (i < 3) ? ~mio_en : 1'b0; address = 16'h3001; r_w = 1'b1; wdata = 16'hFFFF;
      if (ready) begin
        got = 1'b1; rd = rdata;
      end else begin
        @(posedge clk); edges++;
      end
    end
    check("tog_edges", 32'(edges), 32'd4);
    check("tog_data", 32'(rd), 32'h1234);
    @(posedge clk); @(negedge clk);
    mio_en = 1'b0; r_w = 1'b0;
    check("tog_no_write", 32'(mem[1]), 32'h0);
    // request held for 10 cycles
    mio_en = 1'b1; r_w = 1'b0; address = 16'h3000; pulses = 0;
    @(posedge clk);
    repeat (10) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    mio_en = 1'b0;
    repeat (10) @(negedge clk);
    check("held_pulses", 32'(pulses), 32'd1);
    strobe(16'h0041);
    op(1'b0, 16'hFE00, 16'h0, 1'b0, 16'h0);
    check("kbsr_set", 32'(rd), 32'h8000);
    check("io_edges", 32'(edges), 32'd2);
    op(1'b0, 16'hFE02, 16'h0, 1'b0, 16'h0);
    check("kbdr_read", 32'(rd), 32'h0041);
    op(1'b0, 16'hFE00, 16'h0, 1'b0, 16'h0);
    check("kbsr_cleared", 32'(rd), 32'h0000);
    strobe(16'h0041);
    op(1'b0, 16'hFE02, 16'h0, 1'b1, 16'h0042);
    check("kbdr_race_old", 32'(rd), 32'h0041);
    op(1'b0, 16'hFE00, 16'h0, 1'b0, 16'h0);
    check("kbsr_race_kept", 32'(rd), 32'h8000);
    op(1'b0, 16'hFE02, 16'h0, 1'b0, 16'h0);
    check("kbdr_race_new", 32'(rd), 32'h0042);
    op(1'b1, 16'hFE00, 16'hFFFF, 1'b0, 16'h0);
    op(1'b0, 16'hFE00, 16'h0, 1'b0, 16'h0);
    check("kbsr_write_ignored", 32'(rd), 32'h0000);
    op(1'b1, 16'hFE07, 16'hBEEF, 1'b0, 16'h0);
    check("ddr1_wr_edges", 32'(edges), 32'd2);
    check("ddr1_video", video, 32'hBEEF_0000);
    op(1'b0, 16'hFE07, 16'h0, 1'b0, 16'h0);
    check("ddr1_read", 32'(rd), 32'hBEEF);
    op(1'b1, 16'hFE06, 16'h1111, 1'b0, 16'h0);
    check("ddr0_video", video, 32'hBEEF_1111);
    op(1'b1, 16'hFE04, 16'h0000, 1'b0, 16'h0);
    check("dsr_wr_edges", 32'(edges), 32'd2);
    op(1'b0, 16'hFE04, 16'h0, 1'b0, 16'h0);
    check("dsr_read", 32'(rd), 32'h8000);
    op(1'b0, 16'hFE08, 16'h0, 1'b0, 16'h0);
    check("fe08_sram_edges", 32'(edges), 32'd4);
    check("fe08_sram_addr", 32'(sa0), 32'h0FE08);
    check("fe08_data", 32'(rd), 32'hA5A5);
    check("fe08_video_kept", video, 32'hBEEF_1111);
    // reset during a write aborts it
    mio_en = 1'b1; r_w = 1'b1; address = 16'h3010; wdata = 16'h5555;
    @(posedge clk); @(negedge clk);
    check("abort_we_low", 32'(we_n), 32'h0);
    rst = 1'b1; mio_en = 1'b0;
    #1;
    check("abort_strobes", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1f);
    check("abort_video", video, 32'h0);
    @(negedge clk);
    rst = 1'b0; pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    check("abort_no_ready", 32'(pulses), 32'd0);
    check("abort_no_write", 32'(mem[8'h10]), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
